// File: rtl/reaction_timer_if.sv
// Signal bundle between the start-light environment (master) and the reaction timer (slave).
interface reaction_timer_if;
    logic        ms_tick;
    logic [7:0]  lights_in;
    logic        btn;
    logic        lights_off;
    logic [15:0] react_ms;
    logic        valid;
    logic        false_start;
    logic [15:0] best_ms;

    modport master (
        output ms_tick, lights_in, btn,
        input  lights_off, react_ms, valid, false_start, best_ms
    );

    modport slave (
        input  ms_tick, lights_in, btn,
        output lights_off, react_ms, valid, false_start, best_ms
    );
endinterface

// File: rtl/reaction_timer.sv
// Driver reaction timer: random hold after all lamps lit, then measures press latency in ms.
// Define REACTION_BEST_TIME_EN to build the best (minimum) result tracker on best_ms.
module reaction_timer #(
    parameter int MIN_DELAY_MS = 200,
    parameter int MAX_MS       = 9999
) (
    input  logic            clk,
    input  logic            rst,
    reaction_timer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        TIMING,
        DONE,
        FAULT
    } state_t;

    localparam logic [15:0] MAX_COUNT = 16'(MAX_MS);
    localparam logic [15:0] MIN_DELAY = 16'(MIN_DELAY_MS);

    state_t      state_reg, state_next;
    logic [6:0]  lfsr_reg, lfsr_next;
    logic [15:0] delay_reg, delay_next;
    logic [15:0] react_reg, react_next;
    logic        valid_reg, valid_next;
    logic        lights_off_reg;
    logic        false_start_reg;
    logic [2:0]  btn_pipe_reg;
    logic        btn_level;
    logic        press;

    // Two synchroniser stages plus one history flop for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_pipe_reg <= 3'b000;
        end else begin
            btn_pipe_reg <= {btn_pipe_reg[1:0], bus.btn};
        end
    end

    assign btn_level = btn_pipe_reg[1];
    assign press     = btn_pipe_reg[1] & ~btn_pipe_reg[2];

    // x^7 + x^6 + 1 Fibonacci LFSR; a nonzero seed keeps it off the all-zero lockup state.
    assign lfsr_next[0] = lfsr_reg[6] ^ lfsr_reg[5];
    genvar gi;
    generate
        for (gi = 1; gi < 7; gi++) begin : g_lfsr_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        delay_next = delay_reg;
        react_next = react_reg;
        valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                // A press beats an all-lit pattern arriving in the same cycle.
                if (press && (bus.lights_in != 8'h00)) begin
                    state_next = FAULT;
                end else if (bus.lights_in == 8'hFF) begin
                    state_next = DELAY;
                    delay_next = MIN_DELAY + 16'(lfsr_reg);
                end
            end
            DELAY: begin
                if (press) begin
                    state_next = FAULT;
                end else if (bus.ms_tick) begin
                    if (delay_reg <= 16'd1) begin
                        state_next = TIMING;
                        delay_next = 16'd0;
                        react_next = 16'd0;
                    end else begin
                        delay_next = delay_reg - 16'd1;
                    end
                end
            end
            TIMING: begin
                // The press freezes the count, so a coincident tick is dropped.
                if (press) begin
                    state_next = DONE;
                    valid_next = 1'b1;
                end else if (bus.ms_tick && (react_reg < MAX_COUNT)) begin
                    react_next = react_reg + 16'd1;
                end
            end
            DONE, FAULT: begin
                if ((bus.lights_in == 8'h00) && !btn_level) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            lfsr_reg        <= 7'h01;
            delay_reg       <= 16'd0;
            react_reg       <= 16'd0;
            valid_reg       <= 1'b0;
            lights_off_reg  <= 1'b0;
            false_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            lfsr_reg        <= lfsr_next;
            delay_reg       <= delay_next;
            react_reg       <= react_next;
            valid_reg       <= valid_next;
            lights_off_reg  <= (state_next == TIMING) || (state_next == DONE) ||
                               (state_next == FAULT);
            false_start_reg <= (state_next == FAULT);
        end
    end

    assign bus.lights_off  = lights_off_reg;
    assign bus.false_start = false_start_reg;
    assign bus.valid       = valid_reg;
    assign bus.react_ms    = react_reg;

`ifdef REACTION_BEST_TIME_EN
    logic [15:0] best_reg;

    // Compared while valid is high, so the new minimum shows one cycle after the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_reg <= 16'hFFFF;
        end else if (valid_reg && (react_reg < best_reg)) begin
            best_reg <= react_reg;
        end
    end

    assign bus.best_ms = best_reg;
`else
    assign bus.best_ms = 16'hFFFF;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboard bench for reaction_timer: stimulus queues expected results, a monitor checks valid pulses.
`timescale 1ns/1ps
module tb_reaction_timer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reaction_timer_if bus ();

    reaction_timer #(
        .MIN_DELAY_MS(200),
        .MAX_MS      (9999)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int unsigned react;
        int unsigned best;
    } exp_t;

    exp_t        sb[$];
    int          errors   = 0;
    int          checks   = 0;
    int unsigned exp_best = 32'h0000_FFFF;

    function automatic void check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: every valid pulse must match the oldest queued result; best_ms is checked a cycle later.
    initial begin : monitor
        exp_t        e;
        bit          best_pending;
        bit          prev_valid;
        int unsigned best_exp;
        best_pending = 1'b0;
        prev_valid   = 1'b0;
        best_exp     = 0;
        forever begin
            @(negedge clk);
            if (best_pending) begin
                check("best_ms", bus.best_ms, best_exp);
                best_pending = 1'b0;
            end
            if (bus.valid === 1'b1) begin
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL valid_width: valid high for 2+ cycles, required 1");
                end else if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: valid=1 react_ms=%0d false_start=%0d, no result expected",
                             bus.react_ms, bus.false_start);
                end else begin
                    e = sb.pop_front();
                    $display("result: react_ms=%0d expected=%0d best_expected=%0d",
                             bus.react_ms, e.react, e.best);
                    check("react_ms", bus.react_ms, e.react);
                    check("false_start_on_valid", bus.false_start, 0);
                    best_exp     = e.best;
                    best_pending = 1'b1;
                end
            end
            prev_valid = (bus.valid === 1'b1);
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.ms_tick = 1'b1;
            @(negedge clk);
            bus.ms_tick = 1'b0;
        end
    endtask

    task automatic do_reset(input logic [7:0] lights);
        @(negedge clk);
        rst           = 1'b1;
        bus.lights_in = lights;
        bus.btn       = 1'b0;
        bus.ms_tick   = 1'b0;
        exp_best      = 32'h0000_FFFF;
        cyc(3);
        rst = 1'b0;
    endtask

    task automatic release_to_idle();
        bus.btn       = 1'b0;
        bus.lights_in = 8'h00;
        cyc(5);
        check("idle_lights_off", bus.lights_off, 0);
        check("idle_false_start", bus.false_start, 0);
    endtask

    // Queue the expected result, press (optionally with a coincident ms_tick), wait for the monitor.
    task automatic press_expect(input int unsigned r, input bit coincide);
        exp_t        e;
        int unsigned nb;
        int          n;
`ifdef REACTION_BEST_TIME_EN
        nb = (r < exp_best) ? r : exp_best;
`else
        nb = 32'h0000_FFFF;
`endif
        exp_best = nb;
        e.react  = r;
        e.best   = nb;
        sb.push_back(e);
        @(negedge clk);
        bus.btn = 1'b1;
        if (coincide) begin
            cyc(2);
            bus.ms_tick = 1'b1;
            @(negedge clk);
            bus.ms_tick = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        cyc(2);
        check("result_seen_queue_left", sb.size(), 0);
        check("done_lights_off", bus.lights_off, 1);
        check("done_react_hold", bus.react_ms, r);
        release_to_idle();
    endtask

    task automatic wait_lights_off();
        int n;
        bus.lights_in = 8'hFF;
        n = 0;
        while (bus.lights_off !== 1'b1 && n < 400) begin
            tick(1);
            n++;
        end
        check("delay_reached_timing", bus.lights_off, 1);
        checks++;
        if (n < 201 || n > 327) begin
            errors++;
            $display("FAIL delay_range: took %0d ticks, required 201..327", n);
        end
        check("timing_start_react", bus.react_ms, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lights_off"}, bus.lights_off, 0);
        check({tag, "_false_start"}, bus.false_start, 0);
        check({tag, "_valid"}, bus.valid, 0);
        check({tag, "_react_ms"}, bus.react_ms, 0);
        check({tag, "_best_ms"}, bus.best_ms, 16'hFFFF);
    endtask

    initial begin : stimulus
        rst           = 1'b1;
        bus.ms_tick   = 1'b0;
        bus.lights_in = 8'h00;
        bus.btn       = 1'b0;

        // Reset state, then first load from seed 7'h01: exactly 201 ticks of hold.
        @(negedge clk);
        rst           = 1'b1;
        bus.lights_in = 8'hFF;
        cyc(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(200);
        check("delay_200_lights_off", bus.lights_off, 0);
        tick(1);
        check("delay_201_lights_off", bus.lights_off, 1);
        check("timing_start_react", bus.react_ms, 0);
        tick(250);
        check("timing_250_react", bus.react_ms, 250);
        press_expect(250, 1'b0);

        // False start while the start sequence is still building up.
        bus.lights_in = 8'h0F;
        cyc(2);
        bus.btn = 1'b1;
        cyc(4);
        check("fs_0f_false_start", bus.false_start, 1);
        check("fs_0f_lights_off", bus.lights_off, 1);
        check("fs_0f_react_hold", bus.react_ms, 250);
        release_to_idle();

        // Press and all-lit arriving on the same edge in IDLE.
        bus.btn = 1'b1;
        cyc(2);
        bus.lights_in = 8'hFF;
        cyc(2);
        check("fs_simul_false_start", bus.false_start, 1);
        release_to_idle();

        // Press during the random hold.
        bus.lights_in = 8'hFF;
        tick(50);
        check("delay_50_lights_off", bus.lights_off, 0);
        bus.btn = 1'b1;
        cyc(4);
        check("fs_delay_false_start", bus.false_start, 1);
        check("fs_delay_lights_off", bus.lights_off, 1);
        release_to_idle();

        // Reset mid-DELAY and mid-TIMING aborts without a result.
        do_reset(8'hFF);
        tick(100);
        rst = 1'b1;
        cyc(1);
        check_reset_outputs("rst_delay");
        rst = 1'b0;
        exp_best = 32'h0000_FFFF;
        tick(201);
        check("rst_timing_entry", bus.lights_off, 1);
        tick(30);
        check("rst_timing_react", bus.react_ms, 30);
        rst = 1'b1;
        cyc(1);
        check_reset_outputs("rst_timing");
        rst           = 1'b0;
        bus.lights_in = 8'h00;
        cyc(4);
        check("rst_idle_lights_off", bus.lights_off, 0);

        // Best-time sequence 300, 180 (press with coincident tick), 220.
        do_reset(8'h00);
        wait_lights_off();
        tick(300);
        press_expect(300, 1'b0);
        wait_lights_off();
        tick(180);
        press_expect(180, 1'b1);
        wait_lights_off();
        tick(220);
        press_expect(220, 1'b0);

        // Saturation of the reaction count.
        do_reset(8'hFF);
        tick(201);
        check("sat_timing_entry", bus.lights_off, 1);
        tick(12000);
        check("sat_react", bus.react_ms, 9999);
        press_expect(9999, 1'b0);

        cyc(3);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
